// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg
//   Shared definitions for the dec_scan_n decoder/scanner.
//   - state_t     : FSM encoding (IDLE / SCAN / DONE)
//   - MODE_*      : meaning of the 'mode' input
//   - cnt_width() : width of the dwell counter for a given DWELL
package dec_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A DWELL of 1 still needs a one-bit counter so the register exists.
    function automatic int cnt_width(input int dwell);
        int w;
        w = $clog2(dwell);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dec_n_onehot.sv
// dec_n_onehot
//   Combinational N-to-2^N one-hot decoder with enable.
//   Ports:
//     en  in  1      0 forces y to all zeros
//     sel in  N      index of the bit to set
//     y   out 2^N    one-hot (or zero) result
module dec_n_onehot #(
    parameter int N = 3
) (
    input  logic                en,
    input  logic [N-1:0]        sel,
    output logic [(1<<N)-1:0]   y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan_n.sv
// dec_scan_n
//   Registered N-to-2^N one-hot decoder with enable and an autonomous scan
//   mode that walks the outputs one-hot, holding each for DWELL enabled
//   clocks. Intended for display digit / row multiplexing.
//
//   Parameters: N (select width, 1..6), DWELL (clocks per output, >= 1).
//   Ports:
//     clk   in   1     rising-edge clock
//     rst_n in   1     synchronous active-low reset
//     en    in   1     global enable; 0 forces s to zero
//     mode  in   1     0 = direct decode, 1 = scan (sampled only in IDLE)
//     a     in   N     direct-mode select
//     start in   1     one-cycle scan request
//     stop  in   1     abort scan
//     cont  in   1     1 = wrap continuously, 0 = single sweep then done
//     s     out  2^N   registered one-hot output
//     idx   out  N     index currently driven in scan mode
//     busy  out  1     high while in SCAN
//     done  out  1     one-cycle pulse at end of a single sweep
//     last  out  1     (only with DEC_SCAN_N_LAST_EN) final cycle of a sweep
//
//   Optional feature macro: DEC_SCAN_N_LAST_EN adds the 'last' output.
//
//   Control semantics: start and stop are level-sampled pulses, not a
//   valid/ready pair. start is honoured only in IDLE with mode=1, en=1 and
//   stop=0; it is never queued. stop wins over start and over the final
//   dwell of a sweep. busy/done are decoded from the registered state.
module dec_scan_n
    import dec_scan_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        a,
    input  logic                start,
    input  logic                stop,
    input  logic                cont,
    output logic [(1<<N)-1:0]   s,
    output logic [N-1:0]        idx,
    output logic                busy,
    output logic                done
`ifdef DEC_SCAN_N_LAST_EN
    ,
    output logic                last
`endif
);

    localparam int              W        = 1 << N;
    localparam int              CW       = cnt_width(DWELL);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]    IDX_LAST = {N{1'b1}};

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [N-1:0]   idx_nxt;
    logic [N-1:0]   dec_sel;
    logic           dec_en;
    logic [W-1:0]   dec_y;

    // One decoder serves both modes; the next-state logic picks its select
    // and enable so that s is simply the registered decoder output.
    dec_n_onehot #(.N(N)) u_dec (
        .en  (dec_en),
        .sel (dec_sel),
        .y   (dec_y)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        dec_sel   = a;
        dec_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                idx_nxt = '0;
                cnt_nxt = '0;
                if (mode == MODE_DIRECT) begin
                    dec_en = en;
                end else if (start && en && !stop) begin
                    state_nxt = ST_SCAN;
                    dec_en    = 1'b1;
                end
            end

            ST_SCAN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (en) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        // Incrementing past IDX_LAST wraps to 0, which is
                        // the right index for both the cont wrap and DONE.
                        idx_nxt = idx + N'(1);
                        if (idx == IDX_LAST && !cont) begin
                            state_nxt = ST_DONE;
                        end else begin
                            dec_en = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        dec_en  = 1'b1;
                    end
                end
                // en=0: counter and idx frozen, s forced to zero.
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end

            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase

        if (state_nxt == ST_SCAN) begin
            dec_sel = idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            s     <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            s     <= dec_y;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy = (state == ST_SCAN);
    assign done = (state == ST_DONE);

`ifdef DEC_SCAN_N_LAST_EN
    assign last = busy && en && (idx == IDX_LAST) && (cnt == CNT_LAST);
`endif

endmodule

// File: tb/tb_dec_scan_n.sv
// tb_dec_scan_n
//   Bench for dec_scan_n. Two instances (DWELL=4 and DWELL=1, N=3) share
//   the same stimulus. A sweep-position reference model predicts every
//   output each cycle; table vectors and hand sequences add explicit
//   timing checks. Define DEC_SCAN_N_LAST_EN to also check 'last'.
module tb_dec_scan_n;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n, en, mode, start, stop, cont;
    logic [N-1:0]   a;
    logic [W-1:0]   s4, s1;
    logic [N-1:0]   idx4, idx1;
    logic           busy4, busy1, done4, done1;
`ifdef DEC_SCAN_N_LAST_EN
    logic           last4, last1;
`endif

    always #5 clk = ~clk;

    dec_scan_n #(.N(N), .DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .start(start), .stop(stop), .cont(cont),
        .s(s4), .idx(idx4), .busy(busy4), .done(done4)
`ifdef DEC_SCAN_N_LAST_EN
        , .last(last4)
`endif
    );

    dec_scan_n #(.N(N), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .start(start), .stop(stop), .cont(cont),
        .s(s1), .idx(idx1), .busy(busy1), .done(done1)
`ifdef DEC_SCAN_N_LAST_EN
        , .last(last1)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a scan is a position 0..8*dwell-1 counted in
    // enabled cycles; the driven output is position / dwell.
    int dw[2]     = '{4, 1};
    bit m_scan[2] = '{0, 0};
    bit m_done[2] = '{0, 0};
    int m_pos[2]  = '{0, 0};
    int m_s[2]    = '{0, 0};

    typedef struct {
        logic           en;
        logic [N-1:0]   a;
        logic [W-1:0]   exp_s;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int tot;
        tot = W * dw[i];
        if (!rst_n) begin
            m_scan[i] = 0; m_done[i] = 0; m_pos[i] = 0; m_s[i] = 0;
        end else if (m_scan[i]) begin
            if (stop) begin
                m_scan[i] = 0; m_pos[i] = 0; m_s[i] = 0;
            end else if (en) begin
                if (m_pos[i] == tot - 1) begin
                    m_pos[i] = 0;
                    if (cont) begin
                        m_s[i] = 1;
                    end else begin
                        m_scan[i] = 0; m_done[i] = 1; m_s[i] = 0;
                    end
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                    m_s[i] = 1 << (m_pos[i] / dw[i]);
                end
            end else begin
                m_s[i] = 0;
            end
        end else if (m_done[i]) begin
            m_done[i] = 0; m_s[i] = 0;
        end else if (mode && en && start && !stop) begin
            m_scan[i] = 1; m_pos[i] = 0; m_s[i] = 1;
        end else if (!mode && en) begin
            m_s[i] = 1 << a;
        end else begin
            m_s[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("s_dw4", s4, m_s[0]);
        chk("idx_dw4", idx4, m_pos[0] / dw[0]);
        chk("busy_dw4", busy4, m_scan[0]);
        chk("done_dw4", done4, m_done[0]);
        chk("onehot_dw4", $onehot0(s4), 1);
        chk("s_dw1", s1, m_s[1]);
        chk("idx_dw1", idx1, m_pos[1] / dw[1]);
        chk("busy_dw1", busy1, m_scan[1]);
        chk("done_dw1", done1, m_done[1]);
        chk("onehot_dw1", $onehot0(s1), 1);
`ifdef DEC_SCAN_N_LAST_EN
        chk("last_dw4", last4, m_scan[0] && en && (m_pos[0] == W * dw[0] - 1));
        chk("last_dw1", last1, m_scan[1] && en && (m_pos[1] == W * dw[1] - 1));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d4, d1, ln4, lc4, ln1, any_done;

        // Clock/reset
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; a = '0;
        start = 1'b0; stop = 1'b0; cont = 1'b0;
        tick();
        tick();
        chk("reset_s", s4, 0);
        chk("reset_busy", busy4, 0);
        rst_n = 1'b1;
        tick();

        // Direct decode table
        vt[0] = '{1'b1, 3'd0, 8'h01};
        vt[1] = '{1'b1, 3'd1, 8'h02};
        vt[2] = '{1'b1, 3'd2, 8'h04};
        vt[3] = '{1'b1, 3'd3, 8'h08};
        vt[4] = '{1'b1, 3'd4, 8'h10};
        vt[5] = '{1'b1, 3'd5, 8'h20};
        vt[6] = '{1'b1, 3'd6, 8'h40};
        vt[7] = '{1'b1, 3'd7, 8'h80};
        vt[8] = '{1'b0, 3'd5, 8'h00};
        mode = 1'b0;
        for (int i = 0; i < 9; i++) begin
            en = vt[i].en;
            a  = vt[i].a;
            tick();
            chk("direct_dw4", s4, vt[i].exp_s);
            chk("direct_dw1", s1, vt[i].exp_s);
            chk("direct_idx", idx4, 0);
        end

        // Single sweep timing
        en = 1'b1; mode = 1'b1; cont = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        d4 = 0; d1 = 0; ln4 = 0; lc4 = 0; ln1 = 0;
        for (int c = 1; c <= 36; c++) begin
            if (done4 && d4 == 0) d4 = c;
            if (done1 && d1 == 0) d1 = c;
`ifdef DEC_SCAN_N_LAST_EN
            if (last4) begin ln4++; lc4 = c; end
            if (last1) ln1++;
`endif
            if (c == 1)  chk("scan_first", s4, 8'h01);
            if (c == 4)  chk("scan_hold", s4, 8'h01);
            if (c == 5)  chk("scan_next", s4, 8'h02);
            if (c == 32) chk("scan_lastout", s4, 8'h80);
            if (c == 33) begin
                chk("done_s", s4, 0);
                chk("done_busy", busy4, 0);
            end
            if (c == 34) chk("after_done", done4, 0);
            tick();
        end
        chk("done_cycle_dw4", d4, 33);
        chk("done_cycle_dw1", d1, 9);
`ifdef DEC_SCAN_N_LAST_EN
        chk("last_count_dw4", ln4, 1);
        chk("last_cycle_dw4", lc4, 32);
        chk("last_count_dw1", ln1, 1);
`endif

        // Pause with en=0 while idx=2 after two dwell cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        d4 = 0;
        for (int c = 1; c <= 42; c++) begin
            if (done4 && d4 == 0) d4 = c;
            if (c == 10) begin
                chk("pause_pre_idx", idx4, 2);
                chk("pause_pre_s", s4, 8'h04);
            end
            if (c >= 11 && c <= 15) begin
                chk("pause_s", s4, 0);
                chk("pause_idx", idx4, 2);
                chk("pause_busy", busy4, 1);
            end
            if (c == 16 || c == 17) chk("resume_s", s4, 8'h04);
            if (c == 18) chk("resume_next", s4, 8'h08);
            en = !(c >= 10 && c <= 14);
            tick();
        end
        en = 1'b1;
        chk("pause_done_cycle", d4, 38);

        // Continuous wrap, then stop
        cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        any_done = 0; ln4 = 0; lc4 = 0; ln1 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done4 || done1) any_done++;
`ifdef DEC_SCAN_N_LAST_EN
            if (c <= 36 && last4) begin ln4++; lc4 = c; end
            if (c <= 36 && last1) ln1++;
`endif
            if (c == 32) chk("cont_last", s4, 8'h80);
            if (c == 33) begin
                chk("cont_wrap", s4, 8'h01);
                chk("cont_busy", busy4, 1);
            end
            if (c == 37) begin
                chk("stop_s", s4, 0);
                chk("stop_busy", busy4, 0);
                chk("stop_idx", idx4, 0);
                chk("stop_busy_dw1", busy1, 0);
            end
            stop = (c == 36);
            tick();
        end
        stop = 1'b0; cont = 1'b0;
        chk("cont_no_done", any_done, 0);
`ifdef DEC_SCAN_N_LAST_EN
        chk("cont_last_count_dw4", ln4, 1);
        chk("cont_last_cycle_dw4", lc4, 32);
        chk("cont_last_count_dw1", ln1, 4);
`endif

        // start and stop together stay idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", busy4, 0);
        chk("start_stop_s", s4, 0);
        tick();
        chk("start_stop_busy2", busy1, 0);

        // start with en=0 is dropped
        en = 1'b0; start = 1'b1;
        tick();
        en = 1'b1; start = 1'b0;
        chk("start_en0_busy", busy4, 0);
        tick();
        chk("start_en0_busy2", busy4, 0);

        // Reset mid-scan
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("midscan_busy", busy4, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_s", s4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_idx", idx4, 0);
        chk("rst_done", done4, 0);
        rst_n = 1'b1;
        tick();

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            mode  = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 60) == 0);
            cont  = $urandom_range(0, 1);
            a     = N'($urandom);
            rst_n = ($urandom_range(0, 300) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
